// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - bit-serial N-bit adder/subtractor with start/done handshake
module addsub_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Select,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Sum,
  output logic         Carry,
  output logic         Overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, next_state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res_sr;
  logic          carry_r;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          last_step;
  logic          fa_sum;
  logic          fa_cout;

  // Single full-adder slice working on the operand LSBs and the running carry
  always_comb begin
    fa_sum  = a_sr[0] ^ b_sr[0] ^ carry_r;
    fa_cout = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_r) | (b_sr[0] & carry_r);
  end

  // Next-state logic and handshake outputs
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        Busy = 1'b1;
        if (cnt == LAST) begin
          last_step  = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand/result shift registers and the held result; the carry register
  // at the last step is the carry into the MSB, so it feeds Overflow directly
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_r  <= 1'b0;
      cnt      <= '0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept) begin
      a_sr    <= A;
      b_sr    <= B ^ {N{Select}};
      res_sr  <= '0;
      carry_r <= Select;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      a_sr    <= {1'b0, a_sr[N-1:1]};
      b_sr    <= {1'b0, b_sr[N-1:1]};
      res_sr  <= {fa_sum, res_sr[N-1:1]};
      carry_r <= fa_cout;
      cnt     <= cnt + 1'b1;
      if (last_step) begin
        Sum      <= {fa_sum, res_sr[N-1:1]};
        Carry    <= fa_cout;
        Overflow <= carry_r ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - self-checking bench for addsub_serial
module tb_addsub_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Select;
  logic       Busy;
  logic       Done;
  logic [3:0] Sum;
  logic       Carry;
  logic       Overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] sum;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs[10];

  addsub_serial #(.N(4)) dut (
    .clk(clk), .reset(reset), .Start(Start), .A(A), .B(B), .Select(Select),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic sel);
    logic [3:0] bx;
    logic [4:0] f;
    logic       v;
    bx = b ^ {4{sel}};
    f  = {1'b0, a} + {1'b0, bx} + {4'b0, sel};
    v  = (a[3] == bx[3]) && (f[3] != a[3]);
    return {v, f[4], f[3:0]};
  endfunction

  // One operation with Start pulsed for a single cycle; inputs are scrambled after accept
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic sel,
                       input logic [3:0] prev_sum, output int lat, output int busy_n,
                       output logic held_ok, output logic excl_ok);
    @(negedge clk);
    A = a; B = b; Select = sel; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; A = ~a; B = ~b; Select = ~sel;
    lat = 1; busy_n = 0; held_ok = 1'b1; excl_ok = 1'b1;
    while (!Done && lat < 20) begin
      if (Busy) busy_n++;
      if (Sum !== prev_sum) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (Busy) excl_ok = 1'b0;
  endtask

  initial begin
    int         lat, busy_n, n;
    logic       held_ok, excl_ok, saw_done;
    logic [3:0] prev;
    logic [5:0] exp;

    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{4'b1000, 4'b0101, 1'b1, 4'b0011, 1'b1, 1'b1};
    vecs[2] = '{4'b1111, 4'b1000, 1'b1, 4'b0111, 1'b1, 1'b0};
    vecs[3] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[4] = '{4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0};
    vecs[5] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[6] = '{4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[7] = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[8] = '{4'b0111, 4'b1111, 1'b1, 4'b1000, 1'b0, 1'b1};
    vecs[9] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};

    reset = 1'b1; Start = 1'b0; A = '0; B = '0; Select = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", {Busy, Done, Sum, Carry, Overflow}, 8'h00);

    // Directed table
    prev = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sel, prev, lat, busy_n, held_ok, excl_ok);
      check($sformatf("vec%0d_sum", i), Sum, vecs[i].sum);
      check($sformatf("vec%0d_carry", i), Carry, vecs[i].c);
      check($sformatf("vec%0d_overflow", i), Overflow, vecs[i].v);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 4);
      check($sformatf("vec%0d_held", i), held_ok, 1'b1);
      check($sformatf("vec%0d_busy_done_excl", i), excl_ok, 1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), Done, 1'b0);
      check($sformatf("vec%0d_sum_hold", i), Sum, vecs[i].sum);
      prev = vecs[i].sum;
    end

    // Start held high across three back-to-back operations, with Start and operands
    // toggled randomly while shifting
    @(negedge clk);
    A = vecs[4].a; B = vecs[4].b; Select = vecs[4].sel; Start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n = 1;
      while (!Done && n < 20) begin
        A = 4'($urandom); B = 4'($urandom); Select = 1'($urandom); Start = 1'($urandom);
        @(negedge clk);
        n++;
      end
      check($sformatf("stream%0d_interval", j), n, 5);
      check($sformatf("stream%0d_result", j), {Overflow, Carry, Sum},
            {vecs[4+j].v, vecs[4+j].c, vecs[4+j].sum});
      if (j < 2) begin
        A = vecs[5+j].a; B = vecs[5+j].b; Select = vecs[5+j].sel; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    @(negedge clk);
    check("stream_end_done_single", Done, 1'b0);

    // Reset after two shift steps aborts the operation and clears the held result
    @(negedge clk);
    A = 4'b0101; B = 4'b0010; Select = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_abort_busy", Busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_outputs", {Busy, Done, Sum, Carry, Overflow}, 8'h00);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (Done || Busy) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 1'b0);
    do_op(4'b0001, 4'b0001, 1'b0, 4'b0000, lat, busy_n, held_ok, excl_ok);
    check("post_abort_result", {Overflow, Carry, Sum}, 6'b00_0010);
    check("post_abort_latency", lat, 5);
    check("post_abort_held", held_ok, 1'b1);

    // Reset on the same edge as Start wins
    @(negedge clk);
    A = 4'b0011; B = 4'b0011; Select = 1'b0; Start = 1'b1; reset = 1'b1;
    @(negedge clk);
    Start = 1'b0; reset = 1'b0;
    check("reset_vs_start", {Busy, Done, Sum, Carry, Overflow}, 8'h00);
    @(negedge clk);
    check("reset_vs_start_idle", Busy, 1'b0);

    // Exhaustive sweep against the behavioural model
    prev = 4'b0000;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          exp = model(4'(a), 4'(b), 1'(s));
          do_op(4'(a), 4'(b), 1'(s), prev, lat, busy_n, held_ok, excl_ok);
          check($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), {Overflow, Carry, Sum}, exp);
          check($sformatf("sweep_s%0d_a%0d_b%0d_timing", s, a, b),
                {lat[7:0], busy_n[7:0], held_ok, excl_ok}, {8'd5, 8'd4, 1'b1, 1'b1});
          prev = exp[3:0];
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
